// File: rtl/odetojoy_player.sv
// Ode to Joy sequencer: drives the shared note bus with each note followed by a rest gap.
// Registered outputs; START/STOP act on the next edge, STOP beats START, no backpressure.
module odetojoy_player #(
    parameter int HALF_BEAT_TICKS = 12_500_000,
    parameter int GAP_TICKS       = 1_250_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    input  logic       LOOP,
    output logic [3:0] note,
    output logic       playing,
    output logic       done,
    output logic [4:0] index
);
    localparam int CNT_W = $clog2(5 * HALF_BEAT_TICKS);

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;

    localparam logic [4:0] LAST_IDX = 5'd27;

    // Last SOUND count for 2, 3 and 5 half-beat slots, and last GAP count.
    localparam logic [CNT_W-1:0] SOUND_LAST_2 = CNT_W'(2 * HALF_BEAT_TICKS - GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] SOUND_LAST_3 = CNT_W'(3 * HALF_BEAT_TICKS - GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] SOUND_LAST_5 = CNT_W'(5 * HALF_BEAT_TICKS - GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, SOUND, GAP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] sound_last;
    logic [4:0]       idx_n;
    logic             done_n;
    logic             playing_n;
    logic [3:0]       note_n;

    function automatic logic [3:0] song_note(input logic [4:0] i);
        case (i)
            5'd0, 5'd1, 5'd6, 5'd11, 5'd12, 5'd14,
            5'd15, 5'd20, 5'd25:                          song_note = NOTE_E;
            5'd2, 5'd5, 5'd16, 5'd19:                     song_note = NOTE_F;
            5'd3, 5'd4, 5'd17, 5'd18:                     song_note = NOTE_G;
            5'd7, 5'd10, 5'd13, 5'd21, 5'd24, 5'd26:      song_note = NOTE_D;
            5'd8, 5'd9, 5'd22, 5'd23, 5'd27:              song_note = NOTE_C4;
            default:                                      song_note = NOTE_NONE;
        endcase
    endfunction

    always_comb begin
        case (index)
            5'd12, 5'd26: sound_last = SOUND_LAST_3;
            5'd13, 5'd27: sound_last = SOUND_LAST_5;
            default:      sound_last = SOUND_LAST_2;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        idx_n   = index;
        done_n  = 1'b0;

        case (state)
            IDLE: cnt_n = '0;
            SOUND: begin
                if (cnt == sound_last) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (index != LAST_IDX) begin
                        state_n = SOUND;
                        idx_n   = index + 5'd1;
                    end else if (LOOP) begin
                        state_n = SOUND;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase

        // A restart keeps any completion pulse raised in the same cycle.
        if (START) begin
            state_n = SOUND;
            cnt_n   = '0;
            idx_n   = '0;
        end
        if (STOP) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
            done_n  = 1'b0;
        end

        playing_n = (state_n != IDLE);
        note_n    = (state_n == SOUND) ? song_note(idx_n) : NOTE_NONE;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            index   <= '0;
            done    <= 1'b0;
            playing <= 1'b0;
            note    <= NOTE_NONE;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            index   <= idx_n;
            done    <= done_n;
            playing <= playing_n;
            note    <= note_n;
        end
    end
endmodule

// File: tb/tb_odetojoy_player.sv
// Directed bench for odetojoy_player with 4-cycle half-beats and a 1-cycle gap.
module tb_odetojoy_player;
    localparam int HB = 4;
    localparam int GP = 1;

    localparam logic [3:0] N_NONE = 4'd0;
    localparam logic [3:0] N_C4   = 4'd1;
    localparam logic [3:0] N_D    = 4'd2;
    localparam logic [3:0] N_E    = 4'd3;
    localparam logic [3:0] N_F    = 4'd4;
    localparam logic [3:0] N_G    = 4'd5;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic       STOP;
    logic       LOOP;
    logic [3:0] note;
    logic       playing;
    logic       done;
    logic [4:0] index;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] song [28];
    logic [3:0] seen [$];

    odetojoy_player #(.HALF_BEAT_TICKS(HB), .GAP_TICKS(GP)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .STOP   (STOP),
        .LOOP   (LOOP),
        .note   (note),
        .playing(playing),
        .done   (done),
        .index  (index)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    function automatic int units(input int i);
        if (i == 12 || i == 26) return 3;
        if (i == 13 || i == 27) return 5;
        return 2;
    endfunction

    // Expected note and index k edges after the START edge, from cumulative slot positions.
    task automatic exp_at(input int k, output int en, output int ei);
        int pos;
        int s;
        pos = 0;
        en  = 0;
        ei  = 0;
        for (int i = 0; i < 28; i++) begin
            s = units(i) * HB;
            if (k < pos + s) begin
                ei = i;
                en = (k < pos + s - GP) ? int'(song[i]) : 0;
                return;
            end
            pos += s;
        end
    endtask

    // Checks n consecutive edges of a pass; caller stands just after edge 0.
    task automatic check_pass(input string tag, input int n);
        int en;
        int ei;
        logic [3:0] prev;
        prev = N_NONE;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            exp_at(k, en, ei);
            chk({tag, "_note"}, note, en);
            chk({tag, "_index"}, index, ei);
            chk({tag, "_playing"}, playing, 1);
            chk({tag, "_done"}, done, 0);
            if (note != N_NONE && prev == N_NONE) seen.push_back(note);
            prev = note;
        end
    endtask

    initial begin
        song = '{N_E, N_E, N_F, N_G, N_G, N_F, N_E, N_D, N_C4, N_C4, N_D, N_E, N_E, N_D,
                 N_E, N_E, N_F, N_G, N_G, N_F, N_E, N_D, N_C4, N_C4, N_D, N_E, N_D, N_C4};
        RESET = 1'b1;
        START = 1'b0;
        STOP  = 1'b0;
        LOOP  = 1'b0;
        repeat (3) tick();
        chk("rst_note", note, N_NONE);
        chk("rst_playing", playing, 0);
        chk("rst_done", done, 0);
        chk("rst_index", index, 0);
        RESET = 1'b0;
        repeat (2) tick();
        chk("idle_playing", playing, 0);
        chk("idle_note", note, N_NONE);

        // Full song without loop, with scoreboard of note order.
        seen.delete();
        start_pulse();
        check_pass("song", 256);
        chk("sb_count", seen.size(), 28);
        for (int i = 0; i < 28 && i < seen.size(); i++) chk("sb_code", seen[i], song[i]);
        tick();
        chk("end_done", done, 1);
        chk("end_playing", playing, 0);
        chk("end_note", note, N_NONE);
        chk("end_index", index, 0);
        tick();
        chk("end_done_clr", done, 0);
        chk("end_idle", playing, 0);

        // Looping: second pass follows with no idle cycle and no done pulse.
        LOOP = 1'b1;
        start_pulse();
        check_pass("loop1", 256);
        tick();
        check_pass("loop2", 256);
        STOP = 1'b1;
        LOOP = 1'b0;
        tick();
        STOP = 1'b0;
        chk("loop_stop_playing", playing, 0);
        chk("loop_stop_done", done, 0);

        // STOP at edge 50.
        start_pulse();
        repeat (49) tick();
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("stop_note", note, N_NONE);
        chk("stop_playing", playing, 0);
        chk("stop_index", index, 0);
        chk("stop_done", done, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("stop_hold_done", done, 0);
            chk("stop_hold_playing", playing, 0);
        end
        start_pulse();
        chk("restart_note", note, N_E);
        chk("restart_index", index, 0);
        chk("restart_playing", playing, 1);

        // START and STOP together: STOP wins.
        repeat (30) tick();
        START = 1'b1;
        STOP  = 1'b1;
        tick();
        START = 1'b0;
        STOP  = 1'b0;
        chk("both_playing", playing, 0);
        chk("both_note", note, N_NONE);
        tick();
        chk("both_hold", playing, 0);

        // Restart mid-note at edge 100 gives a full first slot.
        start_pulse();
        repeat (99) tick();
        chk("mid_index", index, 12);
        chk("mid_note", note, N_E);
        START = 1'b1;
        tick();
        START = 1'b0;
        check_pass("restart", 9);

        // Asynchronous reset in the gap after index 1.
        start_pulse();
        repeat (15) tick();
        chk("gap_note", note, N_NONE);
        chk("gap_playing", playing, 1);
        chk("gap_index", index, 1);
        #2 RESET = 1'b1;
        #1;
        chk("arst_note", note, N_NONE);
        chk("arst_playing", playing, 0);
        chk("arst_index", index, 0);
        chk("arst_done", done, 0);
        #1 RESET = 1'b0;
        repeat (5) tick();
        chk("post_rst_playing", playing, 0);
        chk("post_rst_note", note, N_NONE);
        start_pulse();
        chk("post_rst_start", note, N_E);
        chk("post_rst_play", playing, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/odetojoy_player.md
# odetojoy_player

Autonomous song sequencer that drives the 4-bit note bus with the Ode to Joy melody, instead of reading it from the switches as the tutor FSM does. It sits between the mode-select logic and the tone generator, muxed onto the same note bus as the switch decoder. Each note is sounded for its duration minus a short articulation gap of `none`. A listener or tutor FSM on the bus therefore sees every note separated by a rest, including repeated notes.

## Interface
- HALF_BEAT_TICKS, 12_500_000 — CLK cycles per half-beat (eighth note); must be ≥ 2.
- GAP_TICKS, 1_250_000 — cycles of `none` at the end of every note slot; must satisfy 1 ≤ GAP_TICKS < HALF_BEAT_TICKS.
- CLK  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-high.
- START  in  1  level-sampled each cycle; starts, or restarts, playback from note 0.
- STOP  in  1  level-sampled; aborts playback immediately.
- LOOP  in  1  sampled at song end; high means restart from note 0 instead of finishing.
- note  out  4  note code on the shared note-parameter set (C4, D, E, F, G, none).
- playing  out  1  high while in SOUND or GAP.
- done  out  1  one-cycle pulse on natural song completion.
- index  out  5  current note index, 0..27.

## Operation
- Song ROM has 28 entries: E E F G G F E D C4 C4 D E E D E E F G G F E D C4 C4 D E D C4.
- Duration is U(i) half-beats:
  - U = 3 at indices 12 and 26.
  - U = 5 at indices 13 and 27.
  - U = 2 everywhere else.
  - Total is 64 half-beats.
- Slot length is S(i) = U(i)·HALF_BEAT_TICKS cycles. The note code is driven for S(i) − GAP_TICKS cycles, then `none` for GAP_TICKS cycles.
- FSM states:
  - IDLE: note = none, playing = 0. START moves to SOUND with index = 0 and the tick counter cleared.
  - SOUND: note = ROM[index]. When the tick count reaches S(index) − GAP_TICKS − 1, go to GAP.
  - GAP: note = none. At the last gap cycle there are three cases:
    - If index < 27: index + 1, then SOUND.
    - If index = 27 and LOOP = 1: index = 0, then SOUND.
    - If index = 27 and LOOP = 0: go to IDLE, assert done for 1 cycle, index = 0.
- The tick counter is wide enough for 5·HALF_BEAT_TICKS − 1 and clears on every state change.
- STOP in any state: next cycle IDLE, note = none, playing = 0, index = 0, no done pulse.
- START and STOP together: STOP wins.
- START while in SOUND or GAP: restart at index 0 in SOUND with a cleared counter. No done pulse.
- START held high in IDLE starts once. While it stays high, it restarts every cycle, so upstream logic must present a single-cycle pulse.
- RESET mid-song: asynchronous return to IDLE with all outputs at reset values.
- done and START in the same cycle: done still pulses, and playback restarts.

## Timing
- Reset values: note = none, playing = 0, done = 0, index = 0, state IDLE.
- All outputs are registered.
- START sampled at edge t gives note = E, playing = 1, index = 0 visible after edge t.
- Note index i occupies edges [T_i, T_i + S(i)), where T_0 = t and T_{i+1} = T_i + S(i).
- The code is valid through edge T_i + S(i) − GAP_TICKS − 1. `none` follows for GAP_TICKS cycles.
- Song length is 64·HALF_BEAT_TICKS cycles. done is high for the single cycle after edge t + 64·HALF_BEAT_TICKS, with playing = 0 in that cycle.
- With LOOP = 1, note = E appears after edge t + 64·HALF_BEAT_TICKS with no idle cycle in between.
- STOP sampled at edge s gives note = none after edge s.

## Test plan
Directed tests use HALF_BEAT_TICKS = 4 and GAP_TICKS = 1.
1. Reset, then START pulse at edge 0:
   - note = E for edges 0–6, none at edge 7, E at edges 8–14.
   - index = 1 from edge 8.
   - playing = 1 throughout.
2. Full song with LOOP = 0:
   - Index 12 (E) spans 12 cycles: 11 cycles of E, then 1 of none.
   - Index 27 (C4) occupies edges 236–255.
   - done = 1 only after edge 256, with playing = 0, note = none, index = 0.
   - Scoreboard checks all 28 codes in order.
3. LOOP = 1 at the end:
   - No done pulse.
   - note = E, index = 0 after edge 256.
   - Second pass timing matches the first.
4. STOP at edge 50:
   - note = none and playing = 0 after edge 50.
   - No done pulse.
   - A later START restarts from index 0 with E.
5. START and STOP high together mid-song: the block stops (STOP wins). START alone at edge 100 mid-note restarts, giving E at index 0 with a full 7-cycle sound window.
6. Asynchronous RESET mid-GAP: all outputs go to reset values immediately, without waiting for a clock edge. Playback stays idle until the next START.
